// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : Bundles the fetch port, the data port and the memory handshake
//            shared by mem_port_arbiter and its environment.
// Modports : master - arbiter view (drives done/rdata/stall and the m_* bus)
//            slave  - environment view (requesters plus memory model)
// Signals  : i_req/i_addr/i_rdata/i_done        instruction fetch port
//            d_req/d_we/d_addr/d_wdata/d_rdata/d_done  data access port
//            stall                              pipeline hold
//            m_req/m_we/m_addr/m_wdata/m_rdata/m_done  unified memory port
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              stall;
  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_done;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_done,
    output i_rdata, i_done, d_rdata, d_done, stall, m_req, m_we, m_addr, m_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_done,
    input  i_rdata, i_done, d_rdata, d_done, stall, m_req, m_we, m_addr, m_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported unified memory between the fetch (I)
//            and data (D) stages. D wins simultaneous requests because it
//            belongs to the older instruction. Raises stall while a
//            requester is waiting.
// Ports    : clk   - system clock, rising edge
//            reset - asynchronous, active-high
//            bus   - mem_port_arbiter_if.master (I port, D port, memory port)
// Options  : MEM_ARB_STARVE_GUARD_EN - when defined, after STARVE_LIMIT
//            consecutive D grants made while I waits, I is granted next.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W       = 30,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic           clk,
  input  wire logic           reset,
  mem_port_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              take_i;
  logic              take_d;
  logic              starve;
  logic              i_done_c;
  logic              d_done_c;

  logic              m_req_q;
  logic              m_we_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [DATA_W-1:0] m_wdata_q;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;

  // Only meaningful while I is actually waiting.
  assign starve = bus.i_req && (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (take_i)
        starve_cnt <= '0;
      else if (take_d && bus.i_req)
        starve_cnt <= starve_cnt + 1'b1;
      else if (!bus.i_req)
        starve_cnt <= '0;
    end
  end
`else
  logic unused_starve_cfg;
  assign unused_starve_cfg = (STARVE_LIMIT > 0);
  assign starve = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next state, grant decisions and completion strobes
  always_comb begin
    next_state = state;
    take_d     = 1'b0;
    take_i     = 1'b0;
    i_done_c   = 1'b0;
    d_done_c   = 1'b0;
    case (state)
      IDLE: begin
        // m_done arriving here belongs to no grant and is ignored.
        take_d = bus.d_req && !starve;
        take_i = bus.i_req && !take_d;
        if (take_d)
          next_state = GNT_D;
        else if (take_i)
          next_state = GNT_I;
      end
      GNT_I: begin
        i_done_c = bus.m_done;
        if (bus.m_done)
          next_state = IDLE;
      end
      GNT_D: begin
        d_done_c = bus.m_done;
        if (bus.m_done)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Memory request registers: loaded on a grant, held until m_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else if (take_d) begin
      m_req_q   <= 1'b1;
      m_we_q    <= bus.d_we;
      m_addr_q  <= bus.d_addr;
      m_wdata_q <= bus.d_wdata;
    end else if (take_i) begin
      m_req_q   <= 1'b1;
      m_we_q    <= 1'b0;
      m_addr_q  <= bus.i_addr;
    end else if (i_done_c || d_done_c) begin
      m_req_q   <= 1'b0;
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;

  // Read data is passed straight through; qualified by the done strobes.
  assign bus.i_rdata = bus.m_rdata;
  assign bus.d_rdata = bus.m_rdata;
  assign bus.i_done  = i_done_c;
  assign bus.d_done  = d_done_c;
  assign bus.stall   = (bus.i_req && !i_done_c) || (bus.d_req && !d_done_c);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter. Acts as both
//            requesters and the memory model through the slave side of the
//            interface.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  int   done_cnt;
  int   i_grants;

  mem_port_arbiter_if #(.ADDR_W(30), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(30), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset       = 1'b1;
    bus.i_req   = 1'b0; bus.i_addr  = '0;
    bus.d_req   = 1'b0; bus.d_we    = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_rdata = '0;   bus.m_done  = 1'b0;

    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_m_req",   64'(bus.m_req),   64'd0);
    chk("rst_m_we",    64'(bus.m_we),    64'd0);
    chk("rst_m_addr",  64'(bus.m_addr),  64'd0);
    chk("rst_m_wdata", 64'(bus.m_wdata), 64'd0);
    chk("rst_idle_outs", {61'd0, bus.i_done, bus.d_done, bus.stall}, 64'd0);
    reset = 1'b0;
    tick();

    // ---------------- single fetch ----------------
    bus.i_req = 1'b1; bus.i_addr = 30'h100;
    #1;
    chk("fetch_c0_stall", 64'(bus.stall), 64'd1);
    chk("fetch_c0_m_req", 64'(bus.m_req), 64'd0);
    tick();
    bus.m_done = 1'b1; bus.m_rdata = 32'hDEADBEEF;
    #1;
    chk("fetch_c1_m_req",  64'(bus.m_req),   64'd1);
    chk("fetch_c1_m_addr", 64'(bus.m_addr),  64'h100);
    chk("fetch_c1_m_we",   64'(bus.m_we),    64'd0);
    chk("fetch_c1_i_done", 64'(bus.i_done),  64'd1);
    chk("fetch_c1_rdata",  64'(bus.i_rdata), 64'hDEADBEEF);
    chk("fetch_c1_stall",  64'(bus.stall),   64'd0);
    chk("fetch_c1_d_done", 64'(bus.d_done),  64'd0);
    tick();
    bus.i_req = 1'b0; bus.m_done = 1'b0;
    #1;
    chk("fetch_c2_m_req",  64'(bus.m_req),  64'd0);
    chk("fetch_c2_i_done", 64'(bus.i_done), 64'd0);
    chk("fetch_c2_stall",  64'(bus.stall),  64'd0);
    tick();

    // ---------------- conflict: D first, then I ----------------
    bus.i_req = 1'b1; bus.i_addr = 30'h200;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 30'h4000; bus.d_wdata = 32'h12345678;
    #1;
    chk("conf_c0_stall", 64'(bus.stall), 64'd1);
    tick();
    bus.m_done = 1'b1; bus.m_rdata = 32'h0;
    #1;
    chk("conf_c1_m_we",    64'(bus.m_we),    64'd1);
    chk("conf_c1_m_addr",  64'(bus.m_addr),  64'h4000);
    chk("conf_c1_m_wdata", 64'(bus.m_wdata), 64'h12345678);
    chk("conf_c1_d_done",  64'(bus.d_done),  64'd1);
    chk("conf_c1_i_done",  64'(bus.i_done),  64'd0);
    chk("conf_c1_stall",   64'(bus.stall),   64'd1);
    tick();
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.m_done = 1'b0;
    #1;
    chk("conf_c2_m_req",  64'(bus.m_req),  64'd0);
    chk("conf_c2_i_done", 64'(bus.i_done), 64'd0);
    chk("conf_c2_stall",  64'(bus.stall),  64'd1);
    tick();
    bus.m_done = 1'b1; bus.m_rdata = 32'hCAFEF00D;
    #1;
    chk("conf_c3_m_req",  64'(bus.m_req),   64'd1);
    chk("conf_c3_m_addr", 64'(bus.m_addr),  64'h200);
    chk("conf_c3_m_we",   64'(bus.m_we),    64'd0);
    chk("conf_c3_i_done", 64'(bus.i_done),  64'd1);
    chk("conf_c3_rdata",  64'(bus.i_rdata), 64'hCAFEF00D);
    tick();
    bus.i_req = 1'b0; bus.m_done = 1'b0;
    tick();

    // ---------------- variable latency load ----------------
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 30'h55; bus.d_wdata = 32'h0;
    done_cnt = 0;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("lat_hold_bus", {bus.m_req, bus.m_we, 32'(bus.m_addr), 30'd0}, {1'b1, 1'b0, 32'h55, 30'd0});
      chk("lat_hold_stall", 64'(bus.stall), 64'd1);
      if (bus.d_done || bus.i_done) done_cnt++;
      tick();
    end
    bus.m_done = 1'b1; bus.m_rdata = 32'h0BADF00D;
    #1;
    chk("lat_m_addr", 64'(bus.m_addr), 64'h55);
    chk("lat_d_done", 64'(bus.d_done), 64'd1);
    chk("lat_rdata",  64'(bus.d_rdata), 64'h0BADF00D);
    if (bus.d_done || bus.i_done) done_cnt++;
    tick();
    bus.d_req = 1'b0; bus.m_done = 1'b0;
    #1;
    if (bus.d_done || bus.i_done) done_cnt++;
    chk("lat_done_pulses", 64'(done_cnt), 64'd1);
    chk("lat_m_req_drop",  64'(bus.m_req), 64'd0);
    tick();

    // ---------------- reset mid-transaction ----------------
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 30'h10; bus.d_wdata = 32'hA5A5A5A5;
    tick();
    #1;
    chk("rmid_m_req_before", 64'(bus.m_req), 64'd1);
    bus.m_done = 1'b1;
    reset = 1'b1;
    #1;
    chk("rmid_m_req_async", 64'(bus.m_req),  64'd0);
    chk("rmid_no_done",     64'(bus.d_done), 64'd0);
    reset = 1'b0; bus.m_done = 1'b0;
    bus.d_addr = 30'h20; bus.d_wdata = 32'h5A5A5A5A;
    tick();
    bus.m_done = 1'b1;
    #1;
    chk("rmid_fresh_addr",  64'(bus.m_addr),  64'h20);
    chk("rmid_fresh_wdata", 64'(bus.m_wdata), 64'h5A5A5A5A);
    chk("rmid_fresh_done",  64'(bus.d_done),  64'd1);
    tick();
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.m_done = 1'b0;
    tick();

    // ---------------- starvation: I and D held high ----------------
    bus.i_req = 1'b1; bus.i_addr = 30'h40;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 30'h30;
    i_grants = 0;
    for (int g = 1; g <= 5; g++) begin
      tick();
      bus.m_done = 1'b1; bus.m_rdata = 32'(g);
      #1;
      chk("starve_m_req", 64'(bus.m_req), 64'd1);
      if (bus.m_addr == 30'h40) i_grants++;
      if (g < 5) begin
        chk("starve_early_is_d", 64'(bus.m_addr), 64'h30);
        chk("starve_early_d_done", 64'(bus.d_done), 64'd1);
      end else begin
`ifdef MEM_ARB_STARVE_GUARD_EN
        chk("starve_5th_is_i", 64'(bus.m_addr), 64'h40);
        chk("starve_5th_i_done", 64'(bus.i_done), 64'd1);
`else
        chk("starve_5th_is_d", 64'(bus.m_addr), 64'h30);
        chk("starve_5th_d_done", 64'(bus.d_done), 64'd1);
`endif
      end
      tick();
      bus.m_done = 1'b0;
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    chk("starve_i_grants", 64'(i_grants), 64'd1);
`else
    chk("starve_i_grants", 64'(i_grants), 64'd0);
`endif
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    tick();

    // ---------------- spurious m_done in IDLE ----------------
    bus.m_done = 1'b1; bus.m_rdata = 32'hFFFFFFFF;
    #1;
    chk("spur_dones", {62'd0, bus.i_done, bus.d_done}, 64'd0);
    chk("spur_stall", 64'(bus.stall), 64'd0);
    tick();
    #1;
    chk("spur_m_req", 64'(bus.m_req), 64'd0);
    bus.m_done = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 30'h77;
    tick();
    bus.m_done = 1'b1; bus.m_rdata = 32'h13572468;
    #1;
    chk("spur_next_addr",  64'(bus.m_addr),  64'h77);
    chk("spur_next_done",  64'(bus.d_done),  64'd1);
    chk("spur_next_rdata", 64'(bus.d_rdata), 64'h13572468);
    tick();
    bus.d_req = 1'b0; bus.m_done = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
